// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock edge monitor.
package clk_mon_pkg;

    localparam int unsigned CNT_W_DEFAULT = 28;
    // Wide enough for LOCK_COUNT up to 15.
    localparam int unsigned MATCH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_LOST
    } mon_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, async active-high reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clock_edge_monitor.sv
// Divided-clock monitor: rising-edge strobes, period measurement, lock and timeout reporting.
// Optional CLK_MON_DUTY_EN adds a high_time output (sync-high cycles in the last period).
module clock_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W           = CNT_W_DEFAULT,
    parameter int unsigned EXPECTED_PERIOD = 38,
    parameter int unsigned TOLERANCE       = 1,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned TIMEOUT_PERIODS = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             div_clk_in,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef CLK_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    localparam logic [CNT_W:0] LO_BOUND = (EXPECTED_PERIOD > TOLERANCE) ?
        (CNT_W+1)'(EXPECTED_PERIOD - TOLERANCE) : '0;
    localparam logic [CNT_W:0]   HI_BOUND     = (CNT_W+1)'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(EXPECTED_PERIOD * TIMEOUT_PERIODS);
    localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);

    logic               w_sync;
    logic               r_prev;
    logic               w_edge;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_match;
    logic               w_timeout_hit;

    mon_state_t         r_state;
    logic [MATCH_W-1:0] r_match_cnt;
    logic               r_edge_pulse;
    logic [CNT_W-1:0]   r_period;
    logic               r_period_valid;
    logic               r_locked;
    logic               r_timeout;

    sync_2ff u_sync (
        .i_clk (clock_in),
        .i_rst (reset),
        .i_d   (div_clk_in),
        .o_q   (w_sync)
    );

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign w_edge = w_sync & ~r_prev;

    // Counter restarts at 1 on the edge so its value in the next edge cycle is the period.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_match       = ({1'b0, r_cnt} >= LO_BOUND) && ({1'b0, r_cnt} <= HI_BOUND);
    assign w_timeout_hit = (r_cnt == TIMEOUT_CNT);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_match_cnt    <= '0;
            r_edge_pulse   <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_edge_pulse   <= w_edge;
            r_period_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        r_state <= ST_MEASURE;
                    end else if (w_timeout_hit) begin
                        r_state   <= ST_LOST;
                        r_timeout <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_edge) begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                        r_match_cnt    <= w_match ? r_match_cnt + MATCH_W'(1) : '0;
                    end else if (r_match_cnt == LOCK_TARGET) begin
                        // Lock is declared the cycle after the qualifying period is reported.
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_LOST;
                        r_timeout   <= 1'b1;
                        r_match_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_edge) begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                        if (!w_match) begin
                            r_state     <= ST_MEASURE;
                            r_match_cnt <= '0;
                            r_locked    <= 1'b0;
                        end
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_LOST;
                        r_timeout   <= 1'b1;
                        r_locked    <= 1'b0;
                        r_match_cnt <= '0;
                    end
                end
                ST_LOST: begin
                    if (w_edge) begin
                        r_state     <= ST_MEASURE;
                        r_timeout   <= 1'b0;
                        r_match_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign edge_pulse   = r_edge_pulse;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign timeout      = r_timeout;

`ifdef CLK_MON_DUTY_EN
    logic             w_period_upd;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_high_time;

    assign w_period_upd = w_edge && (r_state == ST_MEASURE || r_state == ST_LOCKED);

    // Sync is always high in the edge cycle, so the new period's count starts at 1.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_high_cnt  <= '0;
            r_high_time <= '0;
        end else begin
            if (w_period_upd) begin
                r_high_time <= r_high_cnt;
            end
            if (w_edge) begin
                r_high_cnt <= CNT_W'(1);
            end else if (w_sync && r_high_cnt != '1) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
        end
    end

    assign high_time = r_high_time;
`endif

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Self-checking bench for clock_edge_monitor: period table plus lock, timeout and reset sequences.
module tb_clock_edge_monitor;

    localparam int unsigned CNT_W = 28;

    typedef struct {
        int unsigned per;
        logic        exp_locked;
    } vec_t;

    typedef struct {
        logic [CNT_W-1:0] period;
        logic             locked;
        logic [CNT_W-1:0] high;
    } sb_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             div;
    logic             ep;
    logic [CNT_W-1:0] per_out;
    logic             pv;
    logic             lck;
    logic             to;
`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned last_ep_cyc = 0;
    int unsigned rises = 0;
    int unsigned since = 0;
    int unsigned prev_w = 1;
    logic        prev_locked = 1'b0;
    logic        prev_pv = 1'b0;
    logic        prev_ep = 1'b0;
    sb_t         sb_q[$];
    sb_t         mon_e;
    vec_t        vecs[18];

    clock_edge_monitor #(
        .CNT_W           (CNT_W),
        .EXPECTED_PERIOD (38),
        .TOLERANCE       (1),
        .LOCK_COUNT      (4),
        .TIMEOUT_PERIODS (4)
    ) dut (
        .clock_in     (clk),
        .reset        (rst),
        .div_clk_in   (div),
        .edge_pulse   (ep),
        .period       (per_out),
        .period_valid (pv),
        .locked       (lck),
        .timeout      (to)
`ifdef CLK_MON_DUTY_EN
        ,
        .high_time    (high_time)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and timing monitors.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv) begin
                check("pv_pending", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("period", per_out, mon_e.period);
                    check("locked_at_pv", lck, mon_e.locked);
`ifdef CLK_MON_DUTY_EN
                    check("high_time", high_time, mon_e.high);
`endif
                end
            end
            if (lck && !prev_locked) begin
                rises++;
                check("locked_rise_after_pv", prev_pv, 1);
            end
            if (ep) begin
                check("edge_pulse_width", prev_ep, 0);
                last_ep_cyc = cyc;
            end
        end
        prev_locked = lck;
        prev_pv     = pv;
        prev_ep     = ep;
    end

    // Pulse of width w starting per cycles after the previous pulse start.
    task automatic next_pulse(input int unsigned per, input int unsigned w,
                              input logic push, input logic exp_locked);
        repeat (per - since) @(negedge clk);
        if (push) sb_q.push_back('{CNT_W'(per), exp_locked, CNT_W'(prev_w)});
        div = 1'b1;
        repeat (w) @(negedge clk);
        div = 1'b0;
        since  = w;
        prev_w = w;
    endtask

    // First edge out of LOST: strobe 3 cycles after the pulse, timeout clears, no period_valid.
    task automatic lost_restart();
        div = 1'b1;
        @(negedge clk);
        div = 1'b0;
        check("restart_ep_n1", ep, 0);
        check("restart_to_n1", to, 1);
        @(negedge clk);
        check("restart_ep_n2", ep, 0);
        check("restart_to_n2", to, 1);
        @(negedge clk);
        check("restart_ep_n3", ep, 1);
        check("restart_to_n3", to, 0);
        check("restart_pv_n3", pv, 0);
        @(negedge clk);
        check("restart_ep_n4", ep, 0);
        since  = 4;
        prev_w = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ep"}, ep, 0);
        check({tag, "_pv"}, pv, 0);
        check({tag, "_locked"}, lck, 0);
        check({tag, "_timeout"}, to, 0);
        check({tag, "_period"}, per_out, 0);
`ifdef CLK_MON_DUTY_EN
        check({tag, "_high"}, high_time, 0);
`endif
    endtask

    initial begin
        int unsigned first_to;
        int unsigned to_cyc;
        logic        got;

        vecs[0]  = '{38, 1'b0};  vecs[1]  = '{38, 1'b0};
        vecs[2]  = '{38, 1'b0};  vecs[3]  = '{38, 1'b0};
        vecs[4]  = '{41, 1'b0};  vecs[5]  = '{38, 1'b0};
        vecs[6]  = '{38, 1'b0};  vecs[7]  = '{38, 1'b0};
        vecs[8]  = '{38, 1'b0};  vecs[9]  = '{37, 1'b1};
        vecs[10] = '{39, 1'b1};  vecs[11] = '{38, 1'b1};
        vecs[12] = '{36, 1'b0};  vecs[13] = '{38, 1'b0};
        vecs[14] = '{38, 1'b0};  vecs[15] = '{38, 1'b0};
        vecs[16] = '{38, 1'b0};  vecs[17] = '{38, 1'b1};

        rst = 1'b1;
        div = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Posedge index k after release leaves cnt=k+1; timeout appears at index 152 (153rd negedge).
        first_to = 0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (k <= 100) begin
                check("idle_ep", ep, 0);
                check("idle_pv", pv, 0);
            end
            if (to && first_to == 0) first_to = k;
            if (first_to != 0) break;
        end
        check("idle_timeout_cycle", first_to, 153);

        lost_restart();
        foreach (vecs[i]) next_pulse(vecs[i].per, 1, 1'b1, vecs[i].exp_locked);
        check("locked_before_stop", lck, 1);

        to_cyc = 0;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (to) begin
                got = 1'b1;
                to_cyc = cyc;
                break;
            end
        end
        check("stop_timeout_seen", got, 1);
        check("stop_timeout_delay", to_cyc - last_ep_cyc, 152);
        check("stop_locked_dropped", lck, 0);

        lost_restart();
        for (int i = 0; i < 4; i++) next_pulse(38, 1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("relock_after_restart", lck, 1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        check("mid_reset_sb_empty", sb_q.size(), 0);
        @(negedge clk);
        rst   = 1'b0;
        since = 0;

        next_pulse(38, 5, 1'b0, 1'b0);
        next_pulse(38, 5, 1'b1, 1'b0);
        next_pulse(38, 5, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("final_sb_empty", sb_q.size(), 0);
        check("locked_rise_count", rises, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
